spi_slave_regs: RTL and testbench
=================================

// Module: spi_slave_regs
// PURPOSE
//  SPI slave register bank; the receiving end of the SPI master link. Decodes 24-bit frames
//  [ID(8) | ADDR(8) | DATA(8)], MSB first, ss active low, sclk idle low, mode 0.
//  Master drives mosi after falling edges and samples miso on rising edges.
//  ID 8'hFF = write (DATA into reg[ADDR]); ID 8'h00 = read (reg[ADDR] shifted out on miso
//  during the DATA byte). Registers also readable and observable by local logic.
// PARAMETERS
//  SLAVE_IDW  8'hFF  frame ID selecting a write
//  SLAVE_IDR  8'h00  frame ID selecting a read
//  NUM_REGS   16     implemented registers, addr 0..NUM_REGS-1 (1..256)
// PORTS
//  clock      in   1  system clock; sclk/ss/mosi are oversampled in this domain
//  reset      in   1  asynchronous, active-high reset
//  ss         in   1  slave select, active low
//  sclk       in   1  SPI clock from master
//  mosi       in   1  serial data from master
//  miso       out  1  serial data to master
//  loc_addr   in   8  local read address
//  loc_rdata  out  8  reg[loc_addr], combinational; 0 if loc_addr >= NUM_REGS
//  wr_pulse   out  1  one-cycle strobe: SPI write committed
//  wr_addr    out  8  address of last committed write (held)
//  wr_data    out  8  data of last committed write (held)
//  frame_err  out  1  one-cycle strobe: frame aborted or bad ID
// BEHAVIOUR
//  Reset: miso=0, wr_pulse=0, wr_addr=0, wr_data=0, frame_err=0, all regs=0, FSM=IDLE,
//   synchronizers: ss=1, sclk=0, mosi=0. Reset mid-frame discards the frame.
//  Input sync: ss, sclk, mosi each through 2 flops; edges from sync'd sclk vs 1-cycle-delayed
//   copy. Edge-to-action latency: 3 clocks. Requires master half-period >= 4 clocks
//   (master freq >= 3); slower is always legal.
//  bit_cnt (5b): counts rising edges while ss low; cleared when ss high.
//  FSM states:
//   IDLE: miso=0. ss falling -> ID, bit_cnt=0, shift reg cleared.
//   ID: shift mosi on each rise. 8th rise: ==SLAVE_IDW -> ADDR (is_wr=1);
//    ==SLAVE_IDR -> ADDR (is_wr=0); else frame_err pulse -> WAIT.
//   ADDR: shift 8 bits. 16th rise: latch addr. Read: load tx = reg[addr]
//    (0 if addr >= NUM_REGS). -> DATA.
//   DATA: read: miso=tx[7] on 16th fall, then next bit on falls 17..23
//    (valid before rises 17..24). Write: miso=0; shift mosi on rises 17..24.
//    24th rise: write commits if addr < NUM_REGS: reg[addr]<=data; wr_addr/wr_data update;
//    wr_pulse=1 for one cycle. Out-of-range: no reg write, no wr_pulse, no error. -> WAIT.
//   WAIT: ignore further edges (extra bits); miso=0 after 24th fall. ss high -> IDLE.
//  ss rising in ID/ADDR/DATA before 24th rise: discard; no write; frame_err pulse; -> IDLE.
//  ss rising in WAIT -> IDLE, no error. ss high overrides any edge in same cycle.
//  Same-cycle local read and SPI commit to same addr: loc_rdata shows old value;
//   new value appears next cycle.
//  Read frames never modify registers. wr_pulse and frame_err never both high.
// STRUCTURE
//  Shared package/include: SPI_IDW/IDR codes, FRAME_BITS=24, FSM state encodings
//   (common with the master).
//  Sub-module spi_sync_edge: 2-flop synchronizer + rise/fall detect; instanced for sclk, ss
//   (mosi uses sync only). Register array and FSM live in the top.
// TESTING (bench drives frames via the team's spi_master, freq=3 and freq=20)
//  Write 8'hFF,8'h05,8'hA5 -> wr_pulse once, wr_addr=05, wr_data=A5, loc_rdata(05)=A5.
//  Write 5 := A5, then read 8'h00,8'h05 -> master rdata=A5; regs unchanged; no wr_pulse.
//  Frame ID 8'h3C -> frame_err once; miso stays 0; no register change.
//  Write to addr 8'h20 (NUM_REGS=16) -> no wr_pulse, no err; read 8'h20 returns 00.
//  Drop ss after 12 bits -> frame_err once, no write; next full frame processed correctly.
//  Assert reset mid-DATA -> all outputs/regs 0 at once; next frame after release works.

Source files
------------

// File: rtl/spi_slave_regs_pkg.sv
// Shared SPI link definitions: frame ID codes, frame length and FSM state encodings.
package spi_slave_regs_pkg;
    localparam logic [7:0] SPI_IDW    = 8'hFF;
    localparam logic [7:0] SPI_IDR    = 8'h00;
    localparam int         FRAME_BITS = 24;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ID   = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_WAIT = 3'd4
    } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI line plus rise/fall detection
// against a one-cycle-delayed copy of the synchronized value.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic meta_r;
    logic sync_r;
    logic prev_r;

    // synchronizer chain and edge-history flop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
            prev_r <= RESET_VAL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign dout = sync_r;
    assign rise = sync_r & ~prev_r;
    assign fall = ~sync_r & prev_r;
endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave register bank: 24-bit [ID|ADDR|DATA] frames write or read a
// local register array, which local logic can also read combinationally.
module spi_slave_regs
    import spi_slave_regs_pkg::*;
#(
    parameter logic [7:0] SLAVE_IDW = SPI_IDW,
    parameter logic [7:0] SLAVE_IDR = SPI_IDR,
    parameter int         NUM_REGS  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] loc_addr,
    output logic [7:0] loc_rdata,
    output logic       wr_pulse,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err
);
    localparam int         AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NUM_W = 9'(NUM_REGS);

    logic        ss_s, ss_rise_s, ss_fall_s;
    logic        sclk_s, sclk_rise_s, sclk_fall_s;
    logic        mosi_meta_r, mosi_s;
    spi_state_e  state_r, state_nxt_s;
    logic [4:0]  bit_cnt_r;
    logic [7:0]  shift_r, shift_nxt_s;
    logic        is_wr_r;
    logic [7:0]  addr_r, tx_r, tx_load_s;
    logic        miso_r, miso_nxt_s;
    logic        wr_pulse_r, frame_err_r, commit_s, err_s;
    logic [7:0]  wr_addr_r, wr_data_r;
    logic [7:0]  regs_r [NUM_REGS];
    logic        rise_s, last_id_s, last_addr_s, last_data_s, id_valid_s;

    function automatic logic in_range(input logic [7:0] a);
        return ({1'b0, a} < NUM_W);
    endfunction

    function automatic logic [7:0] reg_at(input logic [7:0] a);
        if (in_range(a)) begin
            return regs_r[a[AW-1:0]];
        end else begin
            return 8'h00;
        end
    endfunction

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
        .clock(clock), .reset(reset), .din(ss),
        .dout(ss_s), .rise(ss_rise_s), .fall(ss_fall_s)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clock(clock), .reset(reset), .din(sclk),
        .dout(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    // mosi only needs synchronizing; it is aligned with the sclk detector
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mosi_meta_r <= 1'b0;
            mosi_s      <= 1'b0;
        end else begin
            mosi_meta_r <= mosi;
            mosi_s      <= mosi_meta_r;
        end
    end

    // ss high wins over any sclk edge seen in the same cycle
    assign rise_s      = sclk_rise_s & ~ss_s;
    assign shift_nxt_s = {shift_r[6:0], mosi_s};
    assign last_id_s   = rise_s && (bit_cnt_r == 5'd7);
    assign last_addr_s = rise_s && (bit_cnt_r == 5'd15);
    assign last_data_s = rise_s && (bit_cnt_r == 5'(FRAME_BITS - 1));
    assign id_valid_s  = (shift_nxt_s == SLAVE_IDW) || (shift_nxt_s == SLAVE_IDR);

    // register file read ports: local bus and SPI read-data preload
    always_comb begin
        loc_rdata = reg_at(loc_addr);
        tx_load_s = reg_at(shift_nxt_s);
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: if (ss_fall_s)   state_nxt_s = ST_ID;   else state_nxt_s = ST_IDLE;
            ST_ID: begin
                if (ss_rise_s)        state_nxt_s = ST_IDLE;
                else if (last_id_s)   state_nxt_s = id_valid_s ? ST_ADDR : ST_WAIT;
                else                  state_nxt_s = ST_ID;
            end
            ST_ADDR: begin
                if (ss_rise_s)        state_nxt_s = ST_IDLE;
                else if (last_addr_s) state_nxt_s = ST_DATA;
                else                  state_nxt_s = ST_ADDR;
            end
            ST_DATA: begin
                if (ss_rise_s)        state_nxt_s = ST_IDLE;
                else if (last_data_s) state_nxt_s = ST_WAIT;
                else                  state_nxt_s = ST_DATA;
            end
            ST_WAIT: if (ss_rise_s)   state_nxt_s = ST_IDLE; else state_nxt_s = ST_WAIT;
            default:                  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: strobes and next miso bit (read data goes out on falls 16..23)
    always_comb begin
        miso_nxt_s = miso_r;
        commit_s   = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_IDLE: miso_nxt_s = 1'b0;
            ST_ID: begin
                miso_nxt_s = 1'b0;
                if (ss_rise_s)                    err_s = 1'b1;
                else if (last_id_s && !id_valid_s) err_s = 1'b1;
                else                              err_s = 1'b0;
            end
            ST_ADDR: begin
                miso_nxt_s = 1'b0;
                if (ss_rise_s) err_s = 1'b1; else err_s = 1'b0;
            end
            ST_DATA: begin
                if (ss_rise_s) begin
                    err_s      = 1'b1;
                    miso_nxt_s = 1'b0;
                end else begin
                    if (sclk_fall_s && !is_wr_r) miso_nxt_s = tx_r[~bit_cnt_r[2:0]];
                    else if (is_wr_r)            miso_nxt_s = 1'b0;
                    else                         miso_nxt_s = miso_r;
                    if (last_data_s && is_wr_r && in_range(addr_r)) commit_s = 1'b1;
                    else                                            commit_s = 1'b0;
                end
            end
            ST_WAIT: if (sclk_fall_s || ss_s) miso_nxt_s = 1'b0; else miso_nxt_s = miso_r;
            default: miso_nxt_s = 1'b0;
        endcase
    end

    // frame datapath, register array and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt_r   <= 5'd0;
            shift_r     <= 8'h00;
            is_wr_r     <= 1'b0;
            addr_r      <= 8'h00;
            tx_r        <= 8'h00;
            miso_r      <= 1'b0;
            wr_pulse_r  <= 1'b0;
            frame_err_r <= 1'b0;
            wr_addr_r   <= 8'h00;
            wr_data_r   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 8'h00;
        end else begin
            miso_r      <= miso_nxt_s;
            wr_pulse_r  <= commit_s;
            frame_err_r <= err_s;
            if (ss_s)                                bit_cnt_r <= 5'd0;
            else if (rise_s && bit_cnt_r != 5'd31)  bit_cnt_r <= bit_cnt_r + 5'd1;
            if (ss_s)        shift_r <= 8'h00;
            else if (rise_s) shift_r <= shift_nxt_s;
            if (state_r == ST_ID && last_id_s) is_wr_r <= (shift_nxt_s == SLAVE_IDW);
            if (state_r == ST_ADDR && last_addr_s) begin
                addr_r <= shift_nxt_s;
                tx_r   <= tx_load_s;
            end
            if (commit_s) begin
                regs_r[addr_r[AW-1:0]] <= shift_nxt_s;
                wr_addr_r              <= addr_r;
                wr_data_r              <= shift_nxt_s;
            end
        end
    end

    assign miso      = miso_r;
    assign wr_pulse  = wr_pulse_r;
    assign frame_err = frame_err_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: a bit-level SPI master drives directed and random
// frames; an array model of the register bank predicts every outcome.
module tb_spi_slave_regs;
    localparam int NREG = 16;

    logic       clock;
    logic       reset;
    logic       ss, sclk, mosi, miso;
    logic [7:0] loc_addr, loc_rdata;
    logic       wr_pulse, frame_err;
    logic [7:0] wr_addr, wr_data;

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0, err_cnt = 0, miso_cnt = 0, both_cnt = 0;

    logic [7:0] mdl [NREG];
    logic [7:0] exp_wa, exp_wd;

    spi_slave_regs #(.NUM_REGS(NREG)) dut (
        .clock(clock), .reset(reset), .ss(ss), .sclk(sclk), .mosi(mosi),
        .miso(miso), .loc_addr(loc_addr), .loc_rdata(loc_rdata),
        .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // pulse/level monitors sampled away from the active edge
    always @(negedge clock) begin
        if (wr_pulse)              wr_cnt   <= wr_cnt + 1;
        if (frame_err)             err_cnt  <= err_cnt + 1;
        if (miso)                  miso_cnt <= miso_cnt + 1;
        if (wr_pulse && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        else n_pass++;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // one SPI bit: mosi changes with the falling edge, miso sampled at the rise
    task automatic spi_bit(input logic b, input int half, output logic s);
        mosi = b;
        wait_clk(half);
        sclk = 1'b1;
        s    = miso;
        wait_clk(half);
        sclk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [23:0] fr, input int nbits, input int half,
                            output logic [7:0] rd);
        logic s;
        logic b;
        rd = 8'h00;
        ss = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 24) b = fr[23 - i];
            else        b = 1'($urandom);
            spi_bit(b, half, s);
            if (i >= 16 && i < 24) rd = {rd[6:0], s};
        end
        mosi = 1'b0;
        wait_clk(half);
        ss = 1'b1;
        wait_clk(half + 8);
    endtask

    task automatic do_frame(input logic [7:0] id, input logic [7:0] addr,
                            input logic [7:0] data, input int nbits, input int half);
        int         wr0, err0, mi0;
        logic [7:0] rd, la;
        logic       full, inr, is_w, is_r;
        wr0  = wr_cnt;
        err0 = err_cnt;
        mi0  = miso_cnt;
        spi_xfer({id, addr, data}, nbits, half, rd);
        full = (nbits >= 24);
        inr  = (addr < 8'(NREG));
        is_w = (id == 8'hFF);
        is_r = (id == 8'h00);
        if (full && is_w && inr) begin
            mdl[addr[3:0]] = data;
            exp_wa = addr;
            exp_wd = data;
        end
        chk("wr_pulse_count", 32'(wr_cnt - wr0), (full && is_w && inr) ? 32'd1 : 32'd0);
        chk("frame_err_count", 32'(err_cnt - err0), (!full || (!is_w && !is_r)) ? 32'd1 : 32'd0);
        chk("wr_addr", 32'(wr_addr), 32'(exp_wa));
        chk("wr_data", 32'(wr_data), 32'(exp_wd));
        chk("miso_after_frame", 32'(miso), 32'd0);
        if (full && is_r) chk("read_data", 32'(rd), inr ? 32'(mdl[addr[3:0]]) : 32'd0);
        if (!is_r) chk("miso_quiet", 32'(miso_cnt - mi0), 32'd0);
        la = 8'($urandom_range(0, 31));
        loc_addr = la;
        #1;
        chk("loc_rdata", 32'(loc_rdata), (la < 8'(NREG)) ? 32'(mdl[la[3:0]]) : 32'd0);
    endtask

    function automatic int pick_half();
        if ($urandom_range(0, 3) == 0) return 21;
        else return int'($urandom_range(4, 7));
    endfunction

    initial begin
        logic       s;
        int         wr0;
        logic [7:0] id, ad, da;
        int         kind, nb;
        reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; loc_addr = 8'h00;
        for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
        exp_wa = 8'h00;
        exp_wd = 8'h00;
        wait_clk(3);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_loc_rdata", 32'(loc_rdata), 32'd0);
        reset = 1'b0;
        wait_clk(4);

        // directed frames at fast and slow master rates
        do_frame(8'hFF, 8'h05, 8'hA5, 24, 4);
        do_frame(8'h00, 8'h05, 8'h00, 24, 21);
        do_frame(8'h3C, 8'h07, 8'h55, 24, 4);
        do_frame(8'hFF, 8'h20, 8'h77, 24, 21);
        do_frame(8'h00, 8'h20, 8'h00, 24, 4);
        do_frame(8'hFF, 8'h03, 8'hC3, 12, 4);
        do_frame(8'hFF, 8'h03, 8'hC3, 24, 21);
        do_frame(8'hFF, 8'h0F, 8'h3E, 27, 4);
        do_frame(8'h00, 8'h0F, 8'h00, 24, 4);

        // reset asserted while the DATA byte of a write is in flight
        wr0 = wr_cnt;
        ss  = 1'b0;
        for (int i = 0; i < 20; i++) spi_bit(i < 8 ? 1'b1 : 1'(i[0]), 4, s);
        reset = 1'b1;
        #1;
        chk("midrst_miso", 32'(miso), 32'd0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
        chk("midrst_wr_data", 32'(wr_data), 32'd0);
        chk("midrst_frame_err", 32'(frame_err), 32'd0);
        for (int a = 0; a < NREG; a++) begin
            loc_addr = 8'(a);
            #1;
            chk("midrst_reg", 32'(loc_rdata), 32'd0);
        end
        for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
        exp_wa = 8'h00;
        exp_wd = 8'h00;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(4);
        ss = 1'b1;
        wait_clk(12);
        chk("midrst_no_write", 32'(wr_cnt - wr0), 32'd0);
        do_frame(8'hFF, 8'h0A, 8'h5A, 24, 4);
        do_frame(8'h00, 8'h0A, 8'h00, 24, 4);

        // randomized frame mix
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            ad   = 8'($urandom_range(0, 19));
            da   = 8'($urandom);
            nb   = 24;
            if (kind <= 3)      id = 8'hFF;
            else if (kind <= 6) id = 8'h00;
            else if (kind == 7) id = 8'($urandom_range(1, 254));
            else begin
                id = $urandom_range(0, 1) == 0 ? 8'hFF : 8'h00;
                nb = int'($urandom_range(1, 23));
            end
            if (kind <= 3 && $urandom_range(0, 4) == 0) nb = 24 + int'($urandom_range(1, 3));
            do_frame(id, ad, da, nb, pick_half());
        end

        chk("never_both_strobes", 32'(both_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
